mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 26 ++
 rtl/mem_port_arbiter_rr_arbiter2.sv | 17 +
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory port arbiter: owner codes, control states, burst default.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_CPU  = 2'b01,
        OWN_LDR  = 2'b10
    } owner_e;

    // ST_RR names the round-robin decision taken while idle; it is never held in the state register.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_CPU_LOCK = 2'b01,
        ST_RR       = 2'b10
    } state_e;

    typedef enum logic {
        LAST_CPU = 1'b0,
        LAST_LDR = 1'b1
    } last_e;

    localparam int BURST_LEN_DEFAULT = 4;

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Two-way round-robin pick between CPU and loader; the side not granted last wins a tie.
// Latency: purely combinational.
// Backpressure: a losing requester simply sees no grant and keeps requesting.
module rr_arbiter2
    import mem_port_arbiter_pkg::*;
(
    input  logic  req_cpu,
    input  logic  req_ldr,
    input  last_e last_owner,
    output logic  gnt_cpu,
    output logic  gnt_ldr
);

    assign gnt_cpu = req_cpu && (!req_ldr || last_owner == LAST_LDR);
    assign gnt_ldr = req_ldr && (!req_cpu || last_owner == LAST_CPU);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates CPU and program loader onto one synchronous single-port memory, with CPU burst lock.
// Latency: gnt combinational at T, memory access at T+1, read return (rvalid) at T+2.
// Backpressure: requests are held until gnt; one grant per cycle, CPU lock excludes the loader.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 7,
    parameter int BURST_LEN = BURST_LEN_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_burst,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_gnt,
    output logic              ldr_rvalid,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        owner
);

    localparam int              CNT_W    = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] BEAT_MAX = CNT_W'(BURST_LEN);

    state_e           state, state_n;
    last_e            last_owner, last_owner_n, rr_last;
    logic [CNT_W-1:0] beat, beat_n;
    logic             in_lock, lock_hold, rr_cpu, rr_ldr, acc_cpu;

    assign in_lock   = (state == ST_CPU_LOCK);
    assign lock_hold = in_lock && cpu_req && cpu_burst;
    // Leaving a lock counts as a CPU grant, so a waiting loader takes the next tie.
    assign rr_last   = in_lock ? LAST_CPU : last_owner;

    rr_arbiter2 u_rr (
        .req_cpu    (cpu_req),
        .req_ldr    (ldr_req),
        .last_owner (rr_last),
        .gnt_cpu    (rr_cpu),
        .gnt_ldr    (rr_ldr)
    );

    always_comb begin
        cpu_gnt      = 1'b0;
        ldr_gnt      = 1'b0;
        state_n      = state;
        beat_n       = beat;
        last_owner_n = last_owner;
        if (!reset) begin
            if (lock_hold) begin
                cpu_gnt = 1'b1;
                beat_n  = beat + 1'b1;
                if (beat_n == BEAT_MAX) begin
                    state_n = ST_IDLE;
                    beat_n  = '0;
                end
            end else begin
                cpu_gnt = rr_cpu;
                ldr_gnt = rr_ldr;
                state_n = ST_IDLE;
                beat_n  = '0;
                if (rr_cpu && cpu_burst && BURST_LEN > 1) begin
                    state_n = ST_CPU_LOCK;
                    beat_n  = CNT_W'(1);
                end
            end
            if (cpu_gnt) last_owner_n = LAST_CPU;
            if (ldr_gnt) last_owner_n = LAST_LDR;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            beat       <= '0;
            last_owner <= LAST_LDR;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            acc_cpu    <= 1'b0;
            cpu_rvalid <= 1'b0;
            ldr_rvalid <= 1'b0;
        end else begin
            state      <= state_n;
            beat       <= beat_n;
            last_owner <= last_owner_n;
            mem_en     <= cpu_gnt | ldr_gnt;
            mem_we     <= (cpu_gnt & cpu_we) | (ldr_gnt & ldr_we);
            if (cpu_gnt) begin
                mem_addr  <= cpu_addr;
                mem_wdata <= cpu_wdata;
            end else if (ldr_gnt) begin
                mem_addr  <= ldr_addr;
                mem_wdata <= ldr_wdata;
            end
            acc_cpu    <= cpu_gnt;
            cpu_rvalid <= mem_en & ~mem_we & acc_cpu;
            ldr_rvalid <= mem_en & ~mem_we & ~acc_cpu;
        end
    end

    // Memory read data lands the cycle rvalid is high, so it is steered, not re-registered.
    assign cpu_rdata = cpu_rvalid ? mem_rdata : '0;
    assign ldr_rdata = ldr_rvalid ? mem_rdata : '0;

    always_comb begin
        owner = OWN_NONE;
        if (in_lock)
            owner = OWN_CPU;
        else if (mem_en | cpu_rvalid | ldr_rvalid)
            owner = (last_owner == LAST_CPU) ? OWN_CPU : OWN_LDR;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against a rule-level model.
// A behavioural synchronous memory sits on the mem_* port.
module tb_mem_port_arbiter;

    localparam int AW = 10;
    localparam int DW = 7;
    localparam int BL = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we, cpu_burst, cpu_gnt, cpu_rvalid;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          ldr_req, ldr_we, ldr_gnt, ldr_rvalid;
    logic [AW-1:0] ldr_addr;
    logic [DW-1:0] ldr_wdata, ldr_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [1:0]    owner;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_burst(cpu_burst), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .owner(owner)
    );

    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    // Rule-level model: beats granted in the current lock (0 = unlocked) and who won the last grant.
    int m_beats;
    bit m_last_cpu;

    function automatic int model_grant();
        bit ldr_wins_tie;
        if (m_beats > 0 && cpu_req && cpu_burst) return 1;
        ldr_wins_tie = (m_beats > 0) ? 1'b1 : m_last_cpu;
        if (cpu_req && ldr_req) return ldr_wins_tie ? 2 : 1;
        if (cpu_req) return 1;
        if (ldr_req) return 2;
        return 0;
    endfunction

    task automatic model_commit(input int g);
        if (g == 1) begin
            m_last_cpu = 1'b1;
            if (cpu_burst) begin
                m_beats = m_beats + 1;
                if (m_beats >= BL) m_beats = 0;
            end else begin
                m_beats = 0;
            end
        end else if (g == 2) begin
            m_last_cpu = 1'b0;
            m_beats    = 0;
        end else if (m_beats > 0 && !(cpu_req && cpu_burst)) begin
            m_beats    = 0;
            m_last_cpu = 1'b1;
        end
    endtask

    task automatic idle_inputs();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_burst = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = '0; ldr_wdata = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        m_beats    = 0;
        m_last_cpu = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        cpu_req = 1'b1; ldr_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({cpu_gnt, cpu_rvalid, cpu_rdata, ldr_gnt, ldr_rvalid, ldr_rdata, mem_en, mem_we, mem_addr, mem_wdata, owner} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got gnt=%b%b rv=%b%b mem_en=%b addr=%h owner=%b, want all zero",
                     cpu_gnt, ldr_gnt, cpu_rvalid, ldr_rvalid, mem_en, mem_addr, owner);
        end
        idle_inputs();
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({cpu_gnt, ldr_gnt, mem_en, owner} !== 5'b0) begin
            failures++;
            $display("FAIL reset_idle: got gnt=%b%b mem_en=%b owner=%b, want 0 0 0 00", cpu_gnt, ldr_gnt, mem_en, owner);
        end
    endtask

    task automatic test_cpu_read();
        do_reset();
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 10'h005; ldr_wdata = 7'h2A;
        @(negedge clk);
        checks++;
        if (ldr_gnt !== 1'b1) begin failures++; $display("FAIL preload_gnt: ldr_gnt=%b want 1", ldr_gnt); end
        @(posedge clk); #1;
        idle_inputs();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h005;
        @(negedge clk);
        checks++;
        if ({cpu_gnt, ldr_gnt} !== 2'b10) begin failures++; $display("FAIL read_gnt_T: gnt=%b%b want 10", cpu_gnt, ldr_gnt); end
        @(posedge clk); #1 cpu_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 10'h005}) begin
            failures++; $display("FAIL read_mem_T1: en=%b we=%b addr=%h want 1 0 005", mem_en, mem_we, mem_addr);
        end
        checks++;
        if ({cpu_rvalid, ldr_rvalid, owner} !== 4'b0001) begin
            failures++; $display("FAIL read_T1_state: rv=%b%b owner=%b want 00 01 (write gives no rvalid)", cpu_rvalid, ldr_rvalid, owner);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({cpu_rvalid, cpu_rdata, ldr_rvalid} !== {1'b1, 7'h2A, 1'b0}) begin
            failures++; $display("FAIL read_T2: cpu_rvalid=%b rdata=%h ldr_rvalid=%b want 1 2a 0", cpu_rvalid, cpu_rdata, ldr_rvalid);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({cpu_rvalid, owner} !== 3'b000) begin
            failures++; $display("FAIL read_T3: cpu_rvalid=%b owner=%b want 0 00", cpu_rvalid, owner);
        end
    endtask

    task automatic test_alternate();
        do_reset();
        cpu_req = 1'b1; cpu_addr = 10'h001;
        ldr_req = 1'b1; ldr_addr = 10'h002;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({cpu_gnt, ldr_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                failures++; $display("FAIL alternate[%0d]: gnt=%b%b want %b", i, cpu_gnt, ldr_gnt, (i % 2 == 0) ? 2'b10 : 2'b01);
            end
            @(posedge clk); #1;
        end
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_burst();
        do_reset();
        ldr_req = 1'b1; ldr_addr = 10'h020;
        cpu_req = 1'b1; cpu_burst = 1'b1; cpu_addr = 10'h010;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({cpu_gnt, ldr_gnt} !== ((i < 4) ? 2'b10 : 2'b01)) begin
                failures++; $display("FAIL burst_gnt[%0d]: gnt=%b%b want %b", i, cpu_gnt, ldr_gnt, (i < 4) ? 2'b10 : 2'b01);
            end
            if (i > 0) begin
                checks++;
                if ({mem_en, mem_addr} !== {1'b1, AW'(16 + i - 1)}) begin
                    failures++; $display("FAIL burst_mem[%0d]: en=%b addr=%h want 1 %h", i, mem_en, mem_addr, 16 + i - 1);
                end
                checks++;
                if (owner !== 2'b01) begin failures++; $display("FAIL burst_owner[%0d]: owner=%b want 01", i, owner); end
            end
            @(posedge clk); #1;
            cpu_addr = cpu_addr + 1'b1;
        end
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_burst_drop();
        do_reset();
        ldr_req = 1'b1; ldr_addr = 10'h021;
        cpu_req = 1'b1; cpu_burst = 1'b1; cpu_addr = 10'h010;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({cpu_gnt, ldr_gnt} !== ((i == 2) ? 2'b01 : 2'b10)) begin
                failures++; $display("FAIL burst_drop[%0d]: gnt=%b%b want %b", i, cpu_gnt, ldr_gnt, (i == 2) ? 2'b01 : 2'b10);
            end
            @(posedge clk); #1;
            if (i < 2) cpu_addr = cpu_addr + 1'b1;
            if (i == 1) cpu_burst = 1'b0;
            if (i == 2) ldr_req = 1'b0;
        end
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_write_read();
        do_reset();
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 10'h3FF; ldr_wdata = 7'h7F;
        @(negedge clk);
        checks++;
        if (ldr_gnt !== 1'b1) begin failures++; $display("FAIL wr_gnt: ldr_gnt=%b want 1", ldr_gnt); end
        @(posedge clk); #1;
        idle_inputs();
        cpu_req = 1'b1; cpu_addr = 10'h3FF;
        @(negedge clk);
        checks++;
        if ({cpu_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 1'b1, 10'h3FF, 7'h7F}) begin
            failures++; $display("FAIL wr_mem: cpu_gnt=%b en=%b we=%b addr=%h wdata=%h want 1 1 1 3ff 7f",
                                 cpu_gnt, mem_en, mem_we, mem_addr, mem_wdata);
        end
        @(posedge clk); #1 cpu_req = 1'b0;
        @(negedge clk);
        checks++;
        if (ldr_rvalid !== 1'b0) begin failures++; $display("FAIL wr_no_rvalid: ldr_rvalid=%b want 0", ldr_rvalid); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({cpu_rvalid, cpu_rdata} !== {1'b1, 7'h7F}) begin
            failures++; $display("FAIL rd_after_wr: cpu_rvalid=%b rdata=%h want 1 7f", cpu_rvalid, cpu_rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        cpu_req = 1'b1; cpu_addr = 10'h005;
        @(negedge clk);
        checks++;
        if (cpu_gnt !== 1'b1) begin failures++; $display("FAIL midrst_gnt: cpu_gnt=%b want 1", cpu_gnt); end
        @(posedge clk); #1;
        cpu_req = 1'b0; ldr_req = 1'b1; reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({cpu_gnt, ldr_gnt} !== 2'b00) begin failures++; $display("FAIL midrst_no_gnt: gnt=%b%b want 00", cpu_gnt, ldr_gnt); end
        @(posedge clk); #1;
        reset = 1'b0; ldr_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({cpu_gnt, cpu_rvalid, cpu_rdata, ldr_gnt, ldr_rvalid, ldr_rdata, mem_en, mem_we, mem_addr, mem_wdata, owner} !== '0) begin
            failures++;
            $display("FAIL midrst_outputs: cpu_rvalid=%b rdata=%h mem_en=%b addr=%h owner=%b want all zero",
                     cpu_rvalid, cpu_rdata, mem_en, mem_addr, owner);
        end
        @(posedge clk); #1;
    endtask

    task automatic new_cpu(input int pct);
        cpu_req   = ($urandom_range(0, 99) < pct);
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_burst = ($urandom_range(0, 9) < 7);
        cpu_addr  = AW'($urandom_range(0, 15));
        cpu_wdata = DW'($urandom);
    endtask

    task automatic new_ldr(input int pct);
        ldr_req   = ($urandom_range(0, 99) < pct);
        ldr_we    = 1'($urandom_range(0, 1));
        ldr_addr  = AW'($urandom_range(0, 15));
        ldr_wdata = DW'($urandom);
    endtask

    task automatic test_random();
        logic [DW-1:0] ref_mem [0:15];
        bit            ref_ok  [0:15];
        int            g, p1_g, p2_rd;
        logic          p1_we;
        logic [AW-1:0] p1_addr;
        logic [DW-1:0] p1_wdata, p1_data, p2_data;
        bit            p1_ok, p2_ok;
        logic [1:0]    exp_owner;
        for (int k = 0; k < 16; k++) ref_ok[k] = 1'b0;
        p1_g = 0; p2_rd = 0; p1_ok = 1'b0; p2_ok = 1'b0;
        p1_we = 1'b0; p1_addr = '0; p1_wdata = '0; p1_data = '0; p2_data = '0;
        do_reset();
        new_cpu(70);
        new_ldr(50);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            g = model_grant();
            if (m_beats > 0)                    exp_owner = 2'b01;
            else if (p1_g != 0 || p2_rd != 0)   exp_owner = m_last_cpu ? 2'b01 : 2'b10;
            else                                exp_owner = 2'b00;
            checks++;
            if ({cpu_gnt, ldr_gnt} !== {g == 1, g == 2}) begin
                failures++; $display("FAIL rnd_gnt cyc=%0d: gnt=%b%b want %b%b", cyc, cpu_gnt, ldr_gnt, g == 1, g == 2);
            end
            checks++;
            if (p1_g != 0) begin
                if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, p1_we, p1_addr, p1_wdata}) begin
                    failures++; $display("FAIL rnd_mem cyc=%0d: en=%b we=%b addr=%h wd=%h want 1 %b %h %h",
                                         cyc, mem_en, mem_we, mem_addr, mem_wdata, p1_we, p1_addr, p1_wdata);
                end
            end else if (mem_en !== 1'b0) begin
                failures++; $display("FAIL rnd_mem_idle cyc=%0d: mem_en=%b want 0", cyc, mem_en);
            end
            checks++;
            if ({cpu_rvalid, ldr_rvalid} !== {p2_rd == 1, p2_rd == 2}) begin
                failures++; $display("FAIL rnd_rvalid cyc=%0d: rv=%b%b want %b%b", cyc, cpu_rvalid, ldr_rvalid, p2_rd == 1, p2_rd == 2);
            end
            if (p2_rd != 0 && p2_ok) begin
                checks++;
                if (((p2_rd == 1) ? cpu_rdata : ldr_rdata) !== p2_data) begin
                    failures++; $display("FAIL rnd_rdata cyc=%0d: rdata=%h want %h", cyc,
                                         (p2_rd == 1) ? cpu_rdata : ldr_rdata, p2_data);
                end
            end
            checks++;
            if (owner !== exp_owner) begin
                failures++; $display("FAIL rnd_owner cyc=%0d: owner=%b want %b", cyc, owner, exp_owner);
            end
            p2_rd   = (p1_g != 0 && !p1_we) ? p1_g : 0;
            p2_data = p1_data;
            p2_ok   = p1_ok;
            p1_g    = g;
            if (g != 0) begin
                p1_we    = (g == 1) ? cpu_we    : ldr_we;
                p1_addr  = (g == 1) ? cpu_addr  : ldr_addr;
                p1_wdata = (g == 1) ? cpu_wdata : ldr_wdata;
                if (p1_we) begin
                    ref_mem[p1_addr[3:0]] = p1_wdata;
                    ref_ok[p1_addr[3:0]]  = 1'b1;
                end else begin
                    p1_data = ref_mem[p1_addr[3:0]];
                    p1_ok   = ref_ok[p1_addr[3:0]];
                end
            end
            model_commit(g);
            @(posedge clk); #1;
            if (g == 1)        new_cpu(85);
            else if (!cpu_req) new_cpu(40);
            if (g == 2)        new_ldr(60);
            else if (!ldr_req) new_ldr(30);
        end
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_cpu_read();
        test_alternate();
        test_burst();
        test_burst_drop();
        test_write_read();
        test_reset_mid_read();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
